// File: rtl/systolic_sched_pkg.sv
// Shared definitions for the systolic-array operand scheduler.
//   mode_e  : array control encodings driven on the scheduler's mode port
//   state_e : scheduler FSM states
//   LANE_W  : width of one operand lane
//   drainCycles() : cycles needed to flush the skewed wavefront through a
//                   DIM x DIM array once the last operand has been read
package systolic_sched_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_CLEAR = 2'b01,
    MODE_MAC   = 2'b10
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int LANE_W = 32;

  // The last read still has to travel DIM-1 lanes of skew and DIM-1 hops
  // across the array, plus one cycle for the final MAC to land.
  function automatic int drainCycles(input int dim);
    return 2 * (dim - 1) + 1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth delay line used to stagger one operand lane.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset, clears every stage
//   i_data  : lane value entering the line
//   o_data  : lane value DEPTH cycles later
module skew_line
  import systolic_sched_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = LANE_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  // Plain shift register; reset must clear every stage so that an aborted
  // pass cannot leak stale operands into the array afterwards.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/systolic_sched.sv
// Operand scheduler for an output-stationary DIM x DIM systolic array.
// One start request runs a tile pass: clear the accumulators, stream K
// operand vectors out of the operand buffers, skew them so lane j lags
// lane 0 by j cycles, drain the wavefront, then pulse done.
//
// Ports:
//   clk, rst_n            : clock and synchronous active-low reset
//   start, k_len          : pass request and reduction length (sampled in IDLE)
//   rd_en, rd_addr        : operand-buffer read strobe and index
//   w_rd_data, d_rd_data  : weight / data vectors, 1-cycle read latency
//   weightN_out, dataN_out: skewed lanes to array columns / rows
//   mode                  : array mode (HOLD / CLEAR / MAC)
//   busy, done            : not-idle flag and end-of-pass pulse
//   acc_keep              : skip CLEAR to accumulate onto previous results
//
// Optional feature: define SYSTOLIC_SCHED_ACCUM_EN to add the acc_keep port.
module systolic_sched
  import systolic_sched_pkg::*;
#(
  parameter int DIM = 4,
  parameter int KW  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  output logic                  rd_en,
  output logic [KW-1:0]         rd_addr,
  input  logic [LANE_W*DIM-1:0] w_rd_data,
  input  logic [LANE_W*DIM-1:0] d_rd_data,
  output logic [LANE_W-1:0]     weight0_out,
  output logic [LANE_W-1:0]     weight1_out,
  output logic [LANE_W-1:0]     weight2_out,
  output logic [LANE_W-1:0]     weight3_out,
  output logic [LANE_W-1:0]     data0_out,
  output logic [LANE_W-1:0]     data1_out,
  output logic [LANE_W-1:0]     data2_out,
  output logic [LANE_W-1:0]     data3_out,
  output logic [1:0]            mode,
  output logic                  busy,
  output logic                  done
`ifdef SYSTOLIC_SCHED_ACCUM_EN
  ,
  input  logic                  acc_keep
`endif
);

  localparam logic [KW:0] CNT_ONE    = (KW+1)'(1);
  localparam logic [KW:0] DRAIN_LAST = (KW+1)'(drainCycles(DIM) - 1);

  state_e         r_state, w_nextState;
  logic [KW:0]    r_cnt, w_nextCnt;
  logic [KW:0]    r_kLen, w_nextKLen;
  mode_e          r_mode, w_nextMode;
  logic           r_rdEn, w_nextRdEn;
  logic [KW-1:0]  r_rdAddr, w_nextRdAddr;
  logic           r_busy, r_done;
  logic           r_rdValid;

  // Next-state logic. K is latched on start so later changes to k_len
  // cannot disturb a pass in flight; the counter is one bit wider than K
  // so the maximum length never wraps.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextKLen  = r_kLen;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextKLen = {1'b0, k_len};
          w_nextCnt  = '0;
          if (k_len == '0) begin
            w_nextState = ST_DONE;
          end
`ifdef SYSTOLIC_SCHED_ACCUM_EN
          else if (acc_keep) begin
            w_nextState = ST_FEED;
          end
`endif
          else begin
            w_nextState = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        w_nextState = ST_FEED;
        w_nextCnt   = '0;
      end
      ST_FEED: begin
        if (r_cnt == r_kLen - CNT_ONE) begin
          w_nextState = ST_DRAIN;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_nextState = ST_DONE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + CNT_ONE;
        end
      end
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they can be registered
  // and still line up with the state they describe.
  always_comb begin
    w_nextMode = MODE_HOLD;
    unique case (w_nextState)
      ST_CLEAR:          w_nextMode = MODE_CLEAR;
      ST_FEED, ST_DRAIN: w_nextMode = MODE_MAC;
      default:           w_nextMode = MODE_HOLD;
    endcase
    w_nextRdEn   = (w_nextState == ST_FEED);
    w_nextRdAddr = w_nextRdEn ? w_nextCnt[KW-1:0] : '0;
  end

  // State, counter and registered control outputs. r_rdValid marks the
  // cycle in which the operand buffers present the data just requested.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_kLen    <= '0;
      r_mode    <= MODE_HOLD;
      r_rdEn    <= 1'b0;
      r_rdAddr  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdValid <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_nextCnt;
      r_kLen    <= w_nextKLen;
      r_mode    <= w_nextMode;
      r_rdEn    <= w_nextRdEn;
      r_rdAddr  <= w_nextRdAddr;
      r_busy    <= (w_nextState != ST_IDLE);
      r_done    <= (w_nextState == ST_DONE);
      r_rdValid <= r_rdEn;
    end
  end

  // First operand stage: capture the read data only when it is valid so
  // every lane carries zero outside its operand window.
  logic [LANE_W-1:0] r_wStage [DIM];
  logic [LANE_W-1:0] r_dStage [DIM];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < DIM; j++) begin
        r_wStage[j] <= '0;
        r_dStage[j] <= '0;
      end
    end else begin
      for (int j = 0; j < DIM; j++) begin
        r_wStage[j] <= r_rdValid ? w_rd_data[LANE_W*j +: LANE_W] : '0;
        r_dStage[j] <= r_rdValid ? d_rd_data[LANE_W*j +: LANE_W] : '0;
      end
    end
  end

  logic [LANE_W-1:0] w_wLane [DIM];
  logic [LANE_W-1:0] w_dLane [DIM];

  // Lane j gets j extra cycles of delay to form the diagonal wavefront.
  for (genvar j = 0; j < DIM; j++) begin : g_lane
    if (j == 0) begin : g_direct
      assign w_wLane[j] = r_wStage[j];
      assign w_dLane[j] = r_dStage[j];
    end else begin : g_skew
      skew_line #(.DEPTH(j), .WIDTH(LANE_W)) u_wSkew (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (r_wStage[j]),
        .o_data  (w_wLane[j])
      );
      skew_line #(.DEPTH(j), .WIDTH(LANE_W)) u_dSkew (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (r_dStage[j]),
        .o_data  (w_dLane[j])
      );
    end
  end

  // The array interface has four fixed lane ports; lanes beyond DIM tie off.
  logic [LANE_W-1:0] w_wOut [4];
  logic [LANE_W-1:0] w_dOut [4];

  for (genvar j = 0; j < 4; j++) begin : g_port
    if (j < DIM) begin : g_used
      assign w_wOut[j] = w_wLane[j];
      assign w_dOut[j] = w_dLane[j];
    end else begin : g_tied
      assign w_wOut[j] = '0;
      assign w_dOut[j] = '0;
    end
  end

  assign weight0_out = w_wOut[0];
  assign weight1_out = w_wOut[1];
  assign weight2_out = w_wOut[2];
  assign weight3_out = w_wOut[3];
  assign data0_out   = w_dOut[0];
  assign data1_out   = w_dOut[1];
  assign data2_out   = w_dOut[2];
  assign data3_out   = w_dOut[3];
  assign mode        = r_mode;
  assign rd_en       = r_rdEn;
  assign rd_addr     = r_rdAddr;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_systolic_sched.sv
// Directed bench for systolic_sched. A registered operand-buffer model
// answers reads one cycle later (garbage when not reading), and a 4x4
// output-stationary MAC array model consumes the skewed lanes so pass
// results can be compared with hand-computed matrices.
// Cycle numbering: start is driven in cycle 0; cycle t is observed 1 time
// unit after the t-th rising edge that follows.
module tb_systolic_sched;

  localparam int DIM = 4;
  localparam int KW  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              rd_en;
  logic [KW-1:0]     rd_addr;
  logic [32*DIM-1:0] w_rd_data;
  logic [32*DIM-1:0] d_rd_data;
  logic [31:0]       weight0_out, weight1_out, weight2_out, weight3_out;
  logic [31:0]       data0_out, data1_out, data2_out, data3_out;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
`ifdef SYSTOLIC_SCHED_ACCUM_EN
  logic              acc_keep;
`endif

  int checks = 0;
  int errors = 0;

  bit [32*DIM-1:0] wMem [16];
  bit [32*DIM-1:0] dMem [16];
  bit [31:0]       acc  [4][4];
  bit [31:0]       aReg [4][4];
  bit [31:0]       bReg [4][4];
  logic [31:0]     wLane [4];
  logic [31:0]     dLane [4];

  assign wLane[0] = weight0_out;
  assign wLane[1] = weight1_out;
  assign wLane[2] = weight2_out;
  assign wLane[3] = weight3_out;
  assign dLane[0] = data0_out;
  assign dLane[1] = data1_out;
  assign dLane[2] = data2_out;
  assign dLane[3] = data3_out;

  always #5 clk = ~clk;

  systolic_sched #(.DIM(DIM), .KW(KW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_len       (k_len),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .w_rd_data   (w_rd_data),
    .d_rd_data   (d_rd_data),
    .weight0_out (weight0_out),
    .weight1_out (weight1_out),
    .weight2_out (weight2_out),
    .weight3_out (weight3_out),
    .data0_out   (data0_out),
    .data1_out   (data1_out),
    .data2_out   (data2_out),
    .data3_out   (data3_out),
    .mode        (mode),
    .busy        (busy),
    .done        (done)
`ifdef SYSTOLIC_SCHED_ACCUM_EN
    ,
    .acc_keep    (acc_keep)
`endif
  );

  // Operand buffers with one cycle of read latency; junk when idle so that
  // any leak of unrequested data shows up on the lanes.
  always @(posedge clk) begin
    if (rd_en) begin
      w_rd_data <= wMem[rd_addr[3:0]];
      d_rd_data <= dMem[rd_addr[3:0]];
    end else begin
      w_rd_data <= {DIM{32'hDEADBEEF}};
      d_rd_data <= {DIM{32'hBAADF00D}};
    end
  end

  // Output-stationary array: data flows right along rows, weights flow down
  // columns, PE(i,j) accumulates their product; CLEAR zeroes accumulators.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        bit [31:0] aIn;
        bit [31:0] bIn;
        aIn = (j == 0) ? dLane[i] : aReg[i][(j == 0) ? 0 : j-1];
        bIn = (i == 0) ? wLane[j] : bReg[(i == 0) ? 0 : i-1][j];
        aReg[i][j] <= aIn;
        bReg[i][j] <= bIn;
        if (mode == 2'b01) acc[i][j] <= '0;
        else               acc[i][j] <= acc[i][j] + aIn * bIn;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected array mode in cycle t for a pass of length k whose feed starts
  // in cycle f (2 after a CLEAR, 1 when CLEAR is skipped).
  function automatic logic [1:0] expMode(input int t, input int k, input int f);
    if (k == 0) return 2'b00;
    if (f == 2 && t == 1) return 2'b01;
    if (t >= f && t <= k + f + 6) return 2'b10;
    return 2'b00;
  endfunction

  // Weight lane j of index k = j+1+k, data lane i = i+1, for k = 0,1.
  task automatic loadPatternK2();
    for (int k = 0; k < 16; k++) begin
      wMem[k] = '0;
      dMem[k] = '0;
    end
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        wMem[k][32*j +: 32] = 32'(j + 1 + k);
        dMem[k][32*j +: 32] = 32'(j + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    k_len = '0;
`ifdef SYSTOLIC_SCHED_ACCUM_EN
    acc_keep = 1'b0;
`endif
    repeat (3) tick();
    checks++;
    if (mode !== 2'b00) begin errors++; $display("[TB] FAIL reset_mode got %0d want 0", mode); end
    checks++;
    if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en got %0b want 0", rd_en); end
    checks++;
    if (rd_addr !== '0) begin errors++; $display("[TB] FAIL reset_rd_addr got %0d want 0", rd_addr); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b want 0", done); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (wLane[j] !== 32'd0) begin errors++; $display("[TB] FAIL reset_weight%0d got %0h want 0", j, wLane[j]); end
      checks++;
      if (dLane[j] !== 32'd0) begin errors++; $display("[TB] FAIL reset_data%0d got %0h want 0", j, dLane[j]); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    for (int k = 0; k < 16; k++) begin
      wMem[k] = '0;
      dMem[k] = '0;
    end
    wMem[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    dMem[0] = {32'd8, 32'd7, 32'd6, 32'd5};
    k_len = 8'd1;
    start = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 1) begin
        start = 1'b0;
        k_len = 8'd5;
      end
      checks++;
      if (mode !== expMode(t, 1, 2)) begin errors++; $display("[TB] FAIL single_mode t=%0d got %0d want %0d", t, mode, expMode(t, 1, 2)); end
      checks++;
      if (rd_en !== (t == 2)) begin errors++; $display("[TB] FAIL single_rd_en t=%0d got %0b want %0b", t, rd_en, (t == 2)); end
      checks++;
      if (done !== (t == 10)) begin errors++; $display("[TB] FAIL single_done t=%0d got %0b want %0b", t, done, (t == 10)); end
      checks++;
      if (busy !== (t <= 10)) begin errors++; $display("[TB] FAIL single_busy t=%0d got %0b want %0b", t, busy, (t <= 10)); end
      if (t == 2) begin
        checks++;
        if (rd_addr !== 8'd0) begin errors++; $display("[TB] FAIL single_rd_addr got %0d want 0", rd_addr); end
      end
      for (int j = 0; j < 4; j++) begin
        logic [31:0] wantW;
        logic [31:0] wantD;
        wantW = (t == 4 + j) ? 32'(j + 1) : 32'd0;
        wantD = (t == 4 + j) ? 32'(j + 5) : 32'd0;
        checks++;
        if (wLane[j] !== wantW) begin errors++; $display("[TB] FAIL single_weight%0d t=%0d got %0h want %0h", j, t, wLane[j], wantW); end
        checks++;
        if (dLane[j] !== wantD) begin errors++; $display("[TB] FAIL single_data%0d t=%0d got %0h want %0h", j, t, dLane[j], wantD); end
      end
    end
  endtask

  task automatic test_identity();
    for (int k = 0; k < 16; k++) begin
      wMem[k] = '0;
      dMem[k] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        wMem[k][32*j +: 32] = (k == j) ? 32'd1 : 32'd0;
        dMem[k][32*j +: 32] = 32'(4 * k + j + 1);
      end
    end
    k_len = 8'd4;
    start = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 1) start = 1'b0;
      checks++;
      if (busy !== (t <= 13)) begin errors++; $display("[TB] FAIL ident_busy t=%0d got %0b want %0b", t, busy, (t <= 13)); end
      checks++;
      if (done !== (t == 13)) begin errors++; $display("[TB] FAIL ident_done t=%0d got %0b want %0b", t, done, (t == 13)); end
      checks++;
      if (rd_en !== (t >= 2 && t <= 5)) begin errors++; $display("[TB] FAIL ident_rd_en t=%0d got %0b want %0b", t, rd_en, (t >= 2 && t <= 5)); end
      checks++;
      if (mode !== expMode(t, 4, 2)) begin errors++; $display("[TB] FAIL ident_mode t=%0d got %0d want %0d", t, mode, expMode(t, 4, 2)); end
      if (t >= 2 && t <= 5) begin
        checks++;
        if (rd_addr !== 8'(t - 2)) begin errors++; $display("[TB] FAIL ident_rd_addr t=%0d got %0d want %0d", t, rd_addr, t - 2); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (acc[i][j] !== 32'(4 * j + i + 1)) begin errors++; $display("[TB] FAIL ident_result[%0d][%0d] got %0d want %0d", i, j, acc[i][j], 4 * j + i + 1); end
      end
    end
  endtask

  task automatic test_zero_len();
    k_len = 8'd0;
    start = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (t == 1) start = 1'b0;
      checks++;
      if (done !== (t == 1)) begin errors++; $display("[TB] FAIL zero_done t=%0d got %0b want %0b", t, done, (t == 1)); end
      checks++;
      if (busy !== (t == 1)) begin errors++; $display("[TB] FAIL zero_busy t=%0d got %0b want %0b", t, busy, (t == 1)); end
      checks++;
      if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL zero_rd_en t=%0d got %0b want 0", t, rd_en); end
      checks++;
      if (mode !== 2'b00) begin errors++; $display("[TB] FAIL zero_mode t=%0d got %0d want 0", t, mode); end
    end
  endtask

  task automatic test_back_to_back();
    int reads = 0;
    int dones = 0;
    int doneAt = -1;
    loadPatternK2();
    k_len = 8'd8;
    start = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      tick();
      if (t == 1) start = 1'b0;
      if (t == 4) begin
        start = 1'b1;
        k_len = 8'd3;
      end
      if (t == 5) start = 1'b0;
      if (rd_en === 1'b1) begin
        checks++;
        if (rd_addr !== 8'(reads)) begin errors++; $display("[TB] FAIL b2b_rd_addr t=%0d got %0d want %0d", t, rd_addr, reads); end
        reads++;
      end
      if (done === 1'b1) begin
        dones++;
        doneAt = t;
      end
    end
    checks++;
    if (reads != 8) begin errors++; $display("[TB] FAIL b2b_reads got %0d want 8", reads); end
    checks++;
    if (dones != 1) begin errors++; $display("[TB] FAIL b2b_dones got %0d want 1", dones); end
    checks++;
    if (doneAt != 17) begin errors++; $display("[TB] FAIL b2b_done_cycle got %0d want 17", doneAt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_end got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    loadPatternK2();
    k_len = 8'd2;
    start = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 1) start = 1'b0;
    end
    // Cycle 6 is the third DRAIN cycle; data lane 1 carries index 1 (=2).
    checks++;
    if (dLane[1] !== 32'd2) begin errors++; $display("[TB] FAIL midrst_pre_data1 got %0h want 2", dLane[1]); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (mode !== 2'b00) begin errors++; $display("[TB] FAIL midrst_mode got %0d want 0", mode); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %0b want 0", busy); end
    checks++;
    if (rd_en !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rd_en got %0b want 0", rd_en); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done got %0b want 0", done); end
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (wLane[j] !== 32'd0) begin errors++; $display("[TB] FAIL midrst_weight%0d step=%0d got %0h want 0", j, t, wLane[j]); end
        checks++;
        if (dLane[j] !== 32'd0) begin errors++; $display("[TB] FAIL midrst_data%0d step=%0d got %0h want 0", j, t, dLane[j]); end
      end
      tick();
    end
    k_len = 8'd2;
    start = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 1) start = 1'b0;
      checks++;
      if (done !== (t == 11)) begin errors++; $display("[TB] FAIL midrst_done_cycle t=%0d got %0b want %0b", t, done, (t == 11)); end
      checks++;
      if (busy !== (t <= 11)) begin errors++; $display("[TB] FAIL midrst_busy_pass t=%0d got %0b want %0b", t, busy, (t <= 11)); end
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (acc[i][j] !== 32'((i + 1) * (2 * j + 3))) begin errors++; $display("[TB] FAIL midrst_result[%0d][%0d] got %0d want %0d", i, j, acc[i][j], (i + 1) * (2 * j + 3)); end
      end
    end
  endtask

`ifdef SYSTOLIC_SCHED_ACCUM_EN
  task automatic test_accum();
    loadPatternK2();
    k_len = 8'd2;
    acc_keep = 1'b0;
    start = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t == 1) start = 1'b0;
      checks++;
      if (done !== (t == 11)) begin errors++; $display("[TB] FAIL accum_p1_done t=%0d got %0b want %0b", t, done, (t == 11)); end
    end
    acc_keep = 1'b1;
    start = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t == 1) begin
        start = 1'b0;
        acc_keep = 1'b0;
      end
      checks++;
      if (mode !== expMode(t, 2, 1)) begin errors++; $display("[TB] FAIL accum_p2_mode t=%0d got %0d want %0d", t, mode, expMode(t, 2, 1)); end
      checks++;
      if (rd_en !== (t >= 1 && t <= 2)) begin errors++; $display("[TB] FAIL accum_p2_rd_en t=%0d got %0b want %0b", t, rd_en, (t >= 1 && t <= 2)); end
      checks++;
      if (done !== (t == 10)) begin errors++; $display("[TB] FAIL accum_p2_done t=%0d got %0b want %0b", t, done, (t == 10)); end
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (acc[i][j] !== 32'(2 * (i + 1) * (2 * j + 3))) begin errors++; $display("[TB] FAIL accum_result[%0d][%0d] got %0d want %0d", i, j, acc[i][j], 2 * (i + 1) * (2 * j + 3)); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_identity();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
`ifdef SYSTOLIC_SCHED_ACCUM_EN
    test_accum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
